// File: rtl/reward_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reward_scan_if : handshake and table/packet bus of the reward scan engine  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface reward_scan_if #(
  parameter int W     = 16,
  parameter int IDX_W = 5,
  parameter int TXW   = 2
) ();
  logic             en;
  logic [W-1:0]     myEnergy;
  logic             iHaveData;
  logic             okToSend;
  logic [W-1:0]     myNodeID;
  logic [W-1:0]     hopsFromSink;
  logic [IDX_W:0]   neighborCount;
  logic [W-1:0]     mNodeID;
  logic [W-1:0]     mNodeHops;
  logic [W-1:0]     mNodeQValue;
  logic [W-1:0]     mNodeEnergy;
  logic [IDX_W-1:0] nTableIndex_reward;
  logic [W-1:0]     rSourceID;
  logic [W-1:0]     rEnergyLeft;
  logic [W-1:0]     rQValue;
  logic [W-1:0]     rSourceHops;
  logic [W-1:0]     rDestinationID;
  logic [2:0]       rPacketType;
  logic [TXW-1:0]   tx_setting;
  logic             busy;
  logic             reward_done;

  modport master (
    output en, myEnergy, iHaveData, okToSend, myNodeID, hopsFromSink, neighborCount,
           mNodeID, mNodeHops, mNodeQValue, mNodeEnergy,
    input  nTableIndex_reward, rSourceID, rEnergyLeft, rQValue, rSourceHops,
           rDestinationID, rPacketType, tx_setting, busy, reward_done
  );

  modport slave (
    input  en, myEnergy, iHaveData, okToSend, myNodeID, hopsFromSink, neighborCount,
           mNodeID, mNodeHops, mNodeQValue, mNodeEnergy,
    output nTableIndex_reward, rSourceID, rEnergyLeft, rQValue, rSourceHops,
           rDestinationID, rPacketType, tx_setting, busy, reward_done
  );
endinterface
`default_nettype wire

// File: rtl/reward_scan_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reward_scan_engine : scores neighbor entries, picks next hop, builds packet|
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reward_scan_engine #(
  parameter int                    WORD_WIDTH   = 16,
  parameter int                    NBR_DEPTH    = 32,
  parameter int                    E_SHIFT      = 4,
  parameter int                    H_SHIFT      = 8,
  parameter int                    TX_LEVELS    = 4,
  parameter logic [WORD_WIDTH-1:0] LOW_E_THRESH = 16'h0400
) (
  input  logic         clk,
  input  logic         rst,
  reward_scan_if.slave bus
);
  localparam int IDX_W = $clog2(NBR_DEPTH);
  localparam int TXW   = $clog2(TX_LEVELS);
  localparam int SW    = WORD_WIDTH + 2;

  localparam logic [IDX_W:0]      DEPTH_N = (IDX_W+1)'(NBR_DEPTH);
  localparam logic [IDX_W:0]      ONE_N   = (IDX_W+1)'(1);
  localparam logic [TXW-1:0]      TX_MAX  = TXW'(TX_LEVELS - 1);
  localparam logic [WORD_WIDTH-1:0] BCAST = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_BUILD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]             state, next_state;
  logic [WORD_WIDTH-1:0]  energy_q, hops_q, best_id;
  logic                   data_q;
  logic [IDX_W:0]         n_q, cnt, n_in;
  logic [IDX_W-1:0]       idx;
  logic signed [SW-1:0]   best_score, score;
  logic [SW-1:0]          q_ext, e_ext, h_ext;
  logic [WORD_WIDTH-1:0]  sat_q;
  logic                   take;
  logic                   busy_c, done_c;

  logic [WORD_WIDTH-1:0]  src_id, energy_left, q_val, src_hops, dest_id;
  logic [2:0]             pkt_type;
  logic [TXW-1:0]         tx;

  assign n_in  = (bus.neighborCount > DEPTH_N) ? DEPTH_N : bus.neighborCount;
  assign q_ext = {2'b00, bus.mNodeQValue};
  assign e_ext = SW'(bus.mNodeEnergy >> E_SHIFT);
  assign h_ext = SW'(bus.mNodeHops) << H_SHIFT;
  assign score = $signed(q_ext + e_ext - h_ext);
  // Strictly-greater keeps the lower index on ties; entry 0 always seeds best.
  assign take  = (cnt == ONE_N) || (score > best_score);

  always_comb begin
    sat_q = best_score[WORD_WIDTH-1:0];
    if (best_score[SW-1])
      sat_q = '0;
    else if (|best_score[SW-2:WORD_WIDTH])
      sat_q = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // An empty table still spends one scan cycle, keeping latency at N+4.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.en) next_state = S_SCAN;
      S_SCAN:  if (cnt == n_q) next_state = S_BUILD;
      S_BUILD: next_state = S_WAIT;
      S_WAIT:  if (bus.okToSend) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == S_SCAN) || (state == S_BUILD) || (state == S_WAIT);
    done_c = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      energy_q    <= '0;
      hops_q      <= '0;
      data_q      <= 1'b0;
      n_q         <= '0;
      cnt         <= '0;
      idx         <= '0;
      best_score  <= '0;
      best_id     <= '0;
      src_id      <= '0;
      energy_left <= '0;
      q_val       <= '0;
      src_hops    <= '0;
      dest_id     <= BCAST;
      pkt_type    <= 3'b111;
      tx          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.en) begin
            energy_q   <= bus.myEnergy;
            hops_q     <= bus.hopsFromSink;
            data_q     <= bus.iHaveData;
            n_q        <= n_in;
            cnt        <= '0;
            idx        <= '0;
            best_score <= '0;
            best_id    <= '0;
          end
        end
        S_SCAN: begin
          cnt <= cnt + ONE_N;
          idx <= cnt[IDX_W-1:0] + 1'b1;
          // Read data lags the address by one cycle: cnt refers to entry cnt-1.
          if (cnt != '0 && take) begin
            best_score <= score;
            best_id    <= bus.mNodeID;
          end
        end
        S_BUILD: begin
          src_id      <= bus.myNodeID;
          energy_left <= energy_q;
          src_hops    <= hops_q;
          q_val       <= sat_q;
          if (energy_q < LOW_E_THRESH) begin
            pkt_type <= 3'b110;
            dest_id  <= BCAST;
            tx       <= TX_MAX;
          end else if (data_q && n_q != '0) begin
            pkt_type <= 3'b011;
            dest_id  <= best_id;
            tx       <= '0;
          end else begin
            pkt_type <= 3'b000;
            dest_id  <= BCAST;
            tx       <= TX_MAX;
            if (n_q == '0) q_val <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.nTableIndex_reward = idx;
  assign bus.rSourceID          = src_id;
  assign bus.rEnergyLeft        = energy_left;
  assign bus.rQValue            = q_val;
  assign bus.rSourceHops        = src_hops;
  assign bus.rDestinationID     = dest_id;
  assign bus.rPacketType        = pkt_type;
  assign bus.tx_setting         = tx;
  assign bus.busy               = busy_c;
  assign bus.reward_done        = done_c;
endmodule
`default_nettype wire
